// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - oversampled I2S deserialiser producing parallel left/right sample pairs
module i2s_receiver #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_bclk,
  input  logic                  i_lrclk,
  input  logic                  i_sdata,
  output logic [DATA_WIDTH-1:0] o_data_left,
  output logic [DATA_WIDTH-1:0] o_data_right,
  output logic                  o_data_valid,
  output logic                  o_frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ALIGN, SHIFT, WAIT} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] bclk_sync, lrclk_sync, sdata_sync;
  logic                   bclk_s, lr_s, sdata_s;
  logic                   bclk_prev, prev_lr;
  logic                   bit_stb, slot_start;

  logic [DATA_WIDTH-2:0]  shift_reg;
  logic [DATA_WIDTH-1:0]  captured_word;
  logic [DATA_WIDTH-1:0]  left_hold;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   channel;
  logic                   left_held;

  logic                   shift_en, word_done, frame_err, start_left, start_right;

  assign bclk_s        = bclk_sync[SYNC_STAGES-1];
  assign lr_s          = lrclk_sync[SYNC_STAGES-1];
  assign sdata_s       = sdata_sync[SYNC_STAGES-1];
  assign bit_stb       = bclk_s & ~bclk_prev;
  assign slot_start    = bit_stb & (lr_s != prev_lr);
  assign captured_word = {shift_reg, sdata_s};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
      prev_lr    <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i_bclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], i_lrclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i_sdata};
      bclk_prev  <= bclk_s;
      if (bit_stb) prev_lr <= lr_s;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ALIGN;
    else         state <= next_state;
  end

  always_comb begin
    next_state  = state;
    shift_en    = 1'b0;
    word_done   = 1'b0;
    frame_err   = 1'b0;
    start_left  = 1'b0;
    start_right = 1'b0;
    case (state)
      ALIGN: begin
        if (slot_start && !lr_s) begin
          next_state = SHIFT;
          start_left = 1'b1;
        end
      end
      SHIFT: begin
        // A slot edge here always means the word came up short.
        if (slot_start) begin
          frame_err = 1'b1;
          if (!lr_s) start_left = 1'b1;
          else       next_state = ALIGN;
        end else if (bit_stb) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            word_done  = 1'b1;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (slot_start) begin
          if (!lr_s) begin
            next_state = SHIFT;
            start_left = 1'b1;
          end else if (left_held) begin
            next_state  = SHIFT;
            start_right = 1'b1;
          end else begin
            next_state = ALIGN;
          end
        end
      end
      default: next_state = ALIGN;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_reg     <= '0;
      left_hold     <= '0;
      bit_cnt       <= '0;
      channel       <= 1'b0;
      left_held     <= 1'b0;
      o_data_left   <= '0;
      o_data_right  <= '0;
      o_data_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_data_valid  <= 1'b0;
      o_frame_error <= frame_err;
      if (start_left) begin
        channel   <= 1'b0;
        bit_cnt   <= '0;
        left_held <= 1'b0;
      end
      if (start_right) begin
        channel <= 1'b1;
        bit_cnt <= '0;
      end
      if (frame_err && !start_left) left_held <= 1'b0;
      if (shift_en) begin
        shift_reg <= captured_word[DATA_WIDTH-2:0];
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
      // The right LSB completes the pair; both outputs update in the same cycle.
      if (word_done) begin
        if (!channel) begin
          left_hold <= captured_word;
          left_held <= 1'b1;
        end else begin
          left_held <= 1'b0;
          if (left_held) begin
            o_data_left  <= left_hold;
            o_data_right <= captured_word;
            o_data_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - randomized slot-level bench for i2s_receiver
module tb_i2s_receiver;
  localparam int W = 24;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_bclk  = 1'b0;
  logic         i_lrclk = 1'b0;
  logic         i_sdata = 1'b0;
  logic [W-1:0] o_data_left, o_data_right;
  logic         o_data_valid, o_frame_error;

  i2s_receiver #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_bclk       (i_bclk),
    .i_lrclk      (i_lrclk),
    .i_sdata      (i_sdata),
    .o_data_left  (o_data_left),
    .o_data_right (o_data_right),
    .o_data_valid (o_data_valid),
    .o_frame_error(o_frame_error)
  );

  always #5 i_clock = ~i_clock;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [W-1:0] got_l[$], got_r[$];
  int           got_err = 0, got_both = 0, got_wide = 0;
  logic         prev_valid = 1'b0;

  // Slot list: each slot is one LRCLK phase; bit 0 is the one-bit delay, bits 1..W the word MSB first.
  bit           s_lr[$];
  int           s_len[$];
  logic [W-1:0] s_word[$];
  bit           s_live[$];

  logic [W-1:0] exp_l[$], exp_r[$];
  int           exp_err;
  logic [W-1:0] rst_l, rst_r;
  logic         rst_v;

  always @(negedge i_clock) begin
    if (o_data_valid) begin
      got_l.push_back(o_data_left);
      got_r.push_back(o_data_right);
    end
    if (o_frame_error) got_err++;
    if (o_data_valid && o_frame_error) got_both++;
    if (o_data_valid && prev_valid) got_wide++;
    prev_valid = o_data_valid;
  end

  task automatic add_slot(input bit lr, input int len, input logic [W-1:0] word, input bit live);
    s_lr.push_back(lr);
    s_len.push_back(len);
    s_word.push_back(word);
    s_live.push_back(live);
  endtask

  task automatic clear_all();
    s_lr.delete(); s_len.delete(); s_word.delete(); s_live.delete();
    got_l.delete(); got_r.delete(); exp_l.delete(); exp_r.delete();
    got_err = 0; got_both = 0; got_wide = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_bclk = 1'b0; i_lrclk = 1'b0; i_sdata = 1'b0;
    repeat (4) @(negedge i_clock);
    i_reset = 1'b0;
    clear_all();
  endtask

  // Reference: a left slot with a full word arms the pair, the next full right slot emits it;
  // any slot that ends short while being captured is an error and drops the pending left.
  task automatic build_model();
    bit           have_left;
    logic [W-1:0] lw;
    have_left = 1'b0;
    lw        = '0;
    exp_l.delete(); exp_r.delete(); exp_err = 0;
    foreach (s_lr[i]) begin
      if (!s_live[i]) begin
        have_left = 1'b0;
      end else if (s_lr[i] == 1'b0 || have_left) begin
        if (s_len[i] - 1 >= W) begin
          if (s_lr[i] == 1'b0) begin
            have_left = 1'b1;
            lw        = s_word[i];
          end else begin
            exp_l.push_back(lw);
            exp_r.push_back(s_word[i]);
            have_left = 1'b0;
          end
        end else begin
          exp_err++;
          have_left = 1'b0;
        end
      end
    end
  endtask

  task automatic play_slot(input int idx, input int pulse_bit, input int rel_bit);
    for (int k = 0; k < s_len[idx]; k++) begin
      logic d;
      d = (k >= 1 && k <= W) ? s_word[idx][W-k] : 1'($urandom_range(0, 1));
      i_bclk = 1'b0; i_lrclk = s_lr[idx]; i_sdata = d;
      if (k == rel_bit) i_reset = 1'b0;
      if (k == pulse_bit) begin
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        rst_l = o_data_left; rst_r = o_data_right; rst_v = o_data_valid;
        repeat (3) @(negedge i_clock);
      end else begin
        repeat (4) @(negedge i_clock);
      end
      i_bclk = 1'b1;
      repeat (4) @(negedge i_clock);
    end
  endtask

  task automatic play_all(input int pulse_slot, input int pulse_bit, input int rel_slot, input int rel_bit);
    foreach (s_lr[i]) play_slot(i, (i == pulse_slot) ? pulse_bit : -1, (i == rel_slot) ? rel_bit : -1);
    repeat (8) @(negedge i_clock);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(negedge i_clock);
    vec_cnt++; if (o_data_left !== '0) begin miss_cnt++; $display("FAIL reset_left got %h want 0", o_data_left); end
    vec_cnt++; if (o_data_right !== '0) begin miss_cnt++; $display("FAIL reset_right got %h want 0", o_data_right); end
    vec_cnt++; if (o_data_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_valid got %b want 0", o_data_valid); end
    vec_cnt++; if (o_frame_error !== 1'b0) begin miss_cnt++; $display("FAIL reset_error got %b want 0", o_frame_error); end
  endtask

  task automatic test_64fs();
    do_reset();
    add_slot(1, 32, W'($urandom), 0);
    add_slot(0, 32, 24'h123456, 1);
    add_slot(1, 32, 24'hABCDEF, 1);
    add_slot(0, 4, '0, 0);
    build_model();
    play_all(-1, -1, -1, -1);
    vec_cnt++; if (got_l.size() !== exp_l.size()) begin miss_cnt++; $display("FAIL 64fs_pairs got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      vec_cnt++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        miss_cnt++; $display("FAIL 64fs_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
    vec_cnt++; if (got_err !== exp_err) begin miss_cnt++; $display("FAIL 64fs_errors got %0d want %0d", got_err, exp_err); end
  endtask

  // Shortest slot that still holds a full word after the one-bit delay.
  task automatic test_tight_slots();
    do_reset();
    add_slot(1, W + 1, '0, 0);
    for (int f = 0; f < 2; f++) begin
      add_slot(0, W + 1, 24'h800000, 1);
      add_slot(1, W + 1, 24'h7FFFFF, 1);
    end
    add_slot(0, 4, '0, 0);
    build_model();
    play_all(-1, -1, -1, -1);
    vec_cnt++; if (got_l.size() !== exp_l.size()) begin miss_cnt++; $display("FAIL tight_pairs got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      vec_cnt++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        miss_cnt++; $display("FAIL tight_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
    vec_cnt++; if (got_err !== exp_err) begin miss_cnt++; $display("FAIL tight_errors got %0d want %0d", got_err, exp_err); end
    vec_cnt++; if (got_wide !== 0) begin miss_cnt++; $display("FAIL tight_pulse_width got %0d wide want 0", got_wide); end
  endtask

  task automatic test_release_mid_right();
    i_reset = 1'b1;
    repeat (4) @(negedge i_clock);
    clear_all();
    add_slot(0, 32, W'($urandom), 0);
    add_slot(1, 32, W'($urandom), 0);
    add_slot(0, 32, W'($urandom), 1);
    add_slot(1, 32, W'($urandom), 1);
    add_slot(0, 4, '0, 0);
    build_model();
    play_all(-1, -1, 1, 12);
    vec_cnt++; if (got_l.size() !== exp_l.size()) begin miss_cnt++; $display("FAIL release_pairs got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      vec_cnt++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        miss_cnt++; $display("FAIL release_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
    vec_cnt++; if (got_err !== exp_err) begin miss_cnt++; $display("FAIL release_errors got %0d want %0d", got_err, exp_err); end
  endtask

  task automatic test_truncated_left();
    do_reset();
    add_slot(1, 32, '0, 0);
    add_slot(0, 17, W'($urandom), 1);
    add_slot(1, 32, W'($urandom), 1);
    add_slot(0, 32, 24'h000001, 1);
    add_slot(1, 32, 24'hFFFFFF, 1);
    add_slot(0, 4, '0, 0);
    build_model();
    play_all(-1, -1, -1, -1);
    vec_cnt++; if (got_err !== exp_err) begin miss_cnt++; $display("FAIL trunc_errors got %0d want %0d", got_err, exp_err); end
    vec_cnt++; if (got_l.size() !== exp_l.size()) begin miss_cnt++; $display("FAIL trunc_pairs got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      vec_cnt++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        miss_cnt++; $display("FAIL trunc_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
    vec_cnt++; if (got_both !== 0) begin miss_cnt++; $display("FAIL trunc_overlap got %0d want 0", got_both); end
  endtask

  task automatic test_reset_mid_left();
    do_reset();
    add_slot(1, 32, '0, 0);
    add_slot(0, 32, W'($urandom), 1);
    add_slot(1, 32, W'($urandom), 1);
    add_slot(0, 32, W'($urandom), 0);
    add_slot(1, 32, W'($urandom), 1);
    add_slot(0, 32, W'($urandom), 1);
    add_slot(1, 32, W'($urandom), 1);
    add_slot(0, 4, '0, 0);
    build_model();
    play_all(3, 11, -1, -1);
    vec_cnt++; if (rst_l !== '0) begin miss_cnt++; $display("FAIL midreset_left got %h want 0", rst_l); end
    vec_cnt++; if (rst_r !== '0) begin miss_cnt++; $display("FAIL midreset_right got %h want 0", rst_r); end
    vec_cnt++; if (rst_v !== 1'b0) begin miss_cnt++; $display("FAIL midreset_valid got %b want 0", rst_v); end
    vec_cnt++; if (got_l.size() !== exp_l.size()) begin miss_cnt++; $display("FAIL midreset_pairs got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      vec_cnt++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        miss_cnt++; $display("FAIL midreset_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
    vec_cnt++; if (got_err !== exp_err) begin miss_cnt++; $display("FAIL midreset_errors got %0d want %0d", got_err, exp_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    add_slot(1, 32, '0, 0);
    for (int n = 1; n <= 8; n++) begin
      add_slot(0, $urandom_range(W + 1, 32), W'(n), 1);
      add_slot(1, $urandom_range(W + 1, 32), '0 - W'(n), 1);
    end
    add_slot(0, 4, '0, 0);
    build_model();
    play_all(-1, -1, -1, -1);
    vec_cnt++; if (got_l.size() !== 8) begin miss_cnt++; $display("FAIL ramp_pairs got %0d want 8", got_l.size()); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      vec_cnt++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        miss_cnt++; $display("FAIL ramp_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
    vec_cnt++; if (got_err !== 0) begin miss_cnt++; $display("FAIL ramp_errors got %0d want 0", got_err); end
    vec_cnt++;
    if (o_data_left !== W'(8) || o_data_right !== '0 - W'(8)) begin
      miss_cnt++; $display("FAIL ramp_hold got %h/%h want %h/%h", o_data_left, o_data_right, W'(8), '0 - W'(8));
    end
  endtask

  task automatic test_random_frames();
    do_reset();
    add_slot(1, 32, '0, 0);
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < 2; c++) begin
        int len;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W) : $urandom_range(W + 1, 32);
        add_slot(c[0], len, W'($urandom), 1);
      end
    end
    add_slot(0, 4, '0, 0);
    build_model();
    play_all(-1, -1, -1, -1);
    vec_cnt++; if (got_l.size() !== exp_l.size()) begin miss_cnt++; $display("FAIL random_pairs got %0d want %0d", got_l.size(), exp_l.size()); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      vec_cnt++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        miss_cnt++; $display("FAIL random_pair%0d got %h/%h want %h/%h", i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
    vec_cnt++; if (got_err !== exp_err) begin miss_cnt++; $display("FAIL random_errors got %0d want %0d", got_err, exp_err); end
    vec_cnt++; if (got_both !== 0 || got_wide !== 0) begin miss_cnt++; $display("FAIL random_pulses got overlap %0d wide %0d want 0/0", got_both, got_wide); end
  endtask

  initial begin
    test_reset();
    test_64fs();
    test_tight_slots();
    test_release_mid_right();
    test_truncated_left();
    test_reset_mid_left();
    test_back_to_back();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
